// File: rtl/uart_cmd_if.sv
// Byte-in / control-out bundle between the UART receiver side and the counter command sequencer.
interface uart_cmd_if;
   logic [7:0]  rx_data;
   logic        rx_done;
   logic        run_en;
   logic        mode_up;
   logic        clr;
   logic        load;
   logic [13:0] set_val;
   logic        cmd_err;
   logic        busy;

   modport master (
      output rx_data, rx_done,
      input  run_en, mode_up, clr, load, set_val, cmd_err, busy
   );

   modport slave (
      input  rx_data, rx_done,
      output run_en, mode_up, clr, load, set_val, cmd_err, busy
   );
endinterface

// File: rtl/uart_cmd_ctrl.sv
// ASCII command sequencer: decodes R/M/C/S bytes from uart_rx into counter run, direction,
// clear and 4-digit decimal preload controls, with an inter-byte timeout inside a preload.
module uart_cmd_ctrl #(
   parameter int unsigned TIMEOUT_CYC = 100_000_000,
   parameter int unsigned MAX_VAL     = 9999
) (
   input logic       clk,
   input logic       rst,
   uart_cmd_if.slave bus
);

   localparam int unsigned TW = $clog2(TIMEOUT_CYC);
   localparam int unsigned VW = 14;
   localparam int unsigned DW = 3;

   localparam logic [7:0] CH_R     = 8'h72;
   localparam logic [7:0] CH_M     = 8'h6D;
   localparam logic [7:0] CH_C     = 8'h63;
   localparam logic [7:0] CH_S     = 8'h73;
   localparam logic [7:0] CH_CR    = 8'h0D;
   localparam logic [7:0] CH_LF    = 8'h0A;
   localparam logic [7:0] CH_SPACE = 8'h20;
   localparam logic [7:0] CH_ZERO  = 8'h30;
   localparam logic [7:0] CH_NINE  = 8'h39;

   typedef enum logic {IDLE, SET} state_t;

   state_t          state, state_nxt;
   logic            run_q, run_nxt;
   logic            mode_q, mode_nxt;
   logic            clr_q, clr_nxt;
   logic            load_q, load_nxt;
   logic            err_q, err_nxt;
   logic            busy_q, busy_nxt;
   logic [VW-1:0]   setval_q, setval_nxt;
   logic [VW-1:0]   acc_q, acc_nxt;
   logic [DW-1:0]   digits_q, digits_nxt;
   logic [TW-1:0]   timer_q, timer_nxt;

   logic [7:0]      lower_c;
   logic [7:0]      digit_c;
   logic            is_digit_c;
   logic            is_blank_c;
   logic [VW-1:0]   acc_new_c;

   // Byte classification; OR-ing bit 5 folds upper-case letters onto lower-case.
   always_comb begin
      lower_c    = bus.rx_data | 8'h20;
      digit_c    = bus.rx_data - CH_ZERO;
      is_digit_c = (bus.rx_data >= CH_ZERO) && (bus.rx_data <= CH_NINE);
      is_blank_c = (bus.rx_data == CH_CR) || (bus.rx_data == CH_LF) ||
                   (bus.rx_data == CH_SPACE);
      acc_new_c  = VW'(acc_q * VW'(10)) + VW'(digit_c);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         run_q    <= 1'b0;
         mode_q   <= 1'b1;
         clr_q    <= 1'b0;
         load_q   <= 1'b0;
         err_q    <= 1'b0;
         busy_q   <= 1'b0;
         setval_q <= '0;
         acc_q    <= '0;
         digits_q <= '0;
         timer_q  <= '0;
      end else begin
         state    <= state_nxt;
         run_q    <= run_nxt;
         mode_q   <= mode_nxt;
         clr_q    <= clr_nxt;
         load_q   <= load_nxt;
         err_q    <= err_nxt;
         busy_q   <= busy_nxt;
         setval_q <= setval_nxt;
         acc_q    <= acc_nxt;
         digits_q <= digits_nxt;
         timer_q  <= timer_nxt;
      end
   end

   // Next-state and output decode; a byte always takes priority over the timeout.
   always_comb begin
      state_nxt  = state;
      run_nxt    = run_q;
      mode_nxt   = mode_q;
      clr_nxt    = 1'b0;
      load_nxt   = 1'b0;
      err_nxt    = 1'b0;
      setval_nxt = setval_q;
      acc_nxt    = acc_q;
      digits_nxt = digits_q;
      timer_nxt  = timer_q;

      unique case (state)
         IDLE: begin
            timer_nxt = '0;
            if (bus.rx_done) begin
               case (lower_c)
                  CH_R: run_nxt = !run_q;
                  CH_M: mode_nxt = !mode_q;
                  CH_C: clr_nxt = 1'b1;
                  CH_S: begin
                     state_nxt  = SET;
                     acc_nxt    = '0;
                     digits_nxt = '0;
                  end
                  default: err_nxt = !is_blank_c;
               endcase
            end
         end
         SET: begin
            timer_nxt = timer_q + TW'(1);
            if (bus.rx_done) begin
               timer_nxt = '0;
               if (is_digit_c) begin
                  acc_nxt    = acc_new_c;
                  digits_nxt = digits_q + DW'(1);
                  if (digits_q == DW'(3)) begin
                     state_nxt = IDLE;
                     if (acc_new_c <= VW'(MAX_VAL)) begin
                        setval_nxt = acc_new_c;
                        load_nxt   = 1'b1;
                     end else begin
                        err_nxt = 1'b1;
                     end
                  end
               end else if (bus.rx_data != CH_SPACE) begin
                  err_nxt   = 1'b1;
                  state_nxt = IDLE;
               end
            end else if (timer_q == TW'(TIMEOUT_CYC - 2)) begin
               // Terminal count: the registered pulse lands as the timer reaches TIMEOUT_CYC-1.
               err_nxt   = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase

      busy_nxt = (state_nxt == SET);
   end

   assign bus.run_en  = run_q;
   assign bus.mode_up = mode_q;
   assign bus.clr     = clr_q;
   assign bus.load    = load_q;
   assign bus.set_val = setval_q;
   assign bus.cmd_err = err_q;
   assign bus.busy    = busy_q;

endmodule
